// File: rtl/mips_cpu_lsu_avalon.sv
// MIPS load/store unit onto Avalon-MM: 3+wait edges accept->resp (1 on reject); req_ready only in IDLE.
// Optional LWL/LWR support under LSU_UNALIGNED_EN; without it ops 5/6 are rejected as illegal.
module mips_cpu_lsu_avalon #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [3:0]  req_op_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [31:0] req_rt_old_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic [31:0] avm_address_o,
  output logic [3:0]  avm_byteenable_o,
  output logic        avm_read_o,
  output logic        avm_write_o,
  output logic [31:0] avm_writedata_o,
  input  logic        avm_waitrequest_i,
  input  logic [31:0] avm_readdata_i
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  localparam logic [3:0] OP_LB = 4'd0, OP_LBU = 4'd1, OP_LH = 4'd2, OP_LHU = 4'd3,
                         OP_LW = 4'd4, OP_LWL = 4'd5, OP_LWR = 4'd6,
                         OP_SB = 4'd8, OP_SH = 4'd9, OP_SW = 4'd10;

  state_e      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wd_q, wd_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] rt_q, rt_d;

  logic        legal, misalign, is_store;
  logic [3:0]  be_req;
  logic [31:0] wd_req;
  logic [15:0] lane;
  logic [31:0] load_data;

  // Request decode: lane enables, replicated store data, legality and alignment.
  always_comb begin
    legal    = 1'b1;
    misalign = 1'b0;
    is_store = 1'b0;
    be_req   = 4'b1111;
    wd_req   = 32'd0;
    case (req_op_i)
      OP_LB, OP_LBU: be_req = 4'b0001 << req_addr_i[1:0];
      OP_LH, OP_LHU: begin
        be_req   = 4'b0011 << req_addr_i[1:0];
        misalign = req_addr_i[0];
      end
      OP_LW:         misalign = |req_addr_i[1:0];
`ifdef LSU_UNALIGNED_EN
      OP_LWL, OP_LWR: begin
        be_req = 4'b1111;
      end
`endif
      OP_SB: begin
        be_req   = 4'b0001 << req_addr_i[1:0];
        wd_req   = {4{req_wdata_i[7:0]}};
        is_store = 1'b1;
      end
      OP_SH: begin
        be_req   = 4'b0011 << req_addr_i[1:0];
        wd_req   = {2{req_wdata_i[15:0]}};
        misalign = req_addr_i[0];
        is_store = 1'b1;
      end
      OP_SW: begin
        wd_req   = req_wdata_i;
        misalign = |req_addr_i[1:0];
        is_store = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    lane      = 16'(avm_readdata_i >> {off_q, 3'b000});
    load_data = 32'd0;
    case (op_q)
      OP_LB:  load_data = {{24{lane[7]}}, lane[7:0]};
      OP_LBU: load_data = {24'd0, lane[7:0]};
      OP_LH:  load_data = {{16{lane[15]}}, lane[15:0]};
      OP_LHU: load_data = {16'd0, lane[15:0]};
      OP_LW:  load_data = avm_readdata_i;
`ifdef LSU_UNALIGNED_EN
      // ~off_q == 3-offset for a 2-bit offset.
      OP_LWL: load_data = (avm_readdata_i << {~off_q, 3'b000})
                        | (rt_q & ~(32'hFFFF_FFFF << {~off_q, 3'b000}));
      OP_LWR: load_data = (avm_readdata_i >> {off_q, 3'b000})
                        | (rt_q & ~(32'hFFFF_FFFF >> {off_q, 3'b000}));
`endif
      default: load_data = 32'd0;
    endcase
  end

`ifndef LSU_UNALIGNED_EN
  logic unused_rt_old;
  assign unused_rt_old = ^req_rt_old_i;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    off_d   = off_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wd_d    = wd_q;
    read_d  = read_q;
    write_d = write_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    rt_d    = rt_q;
    case (state_q)
      S_IDLE: if (req_valid_i) begin
        op_d  = req_op_i;
        off_d = req_addr_i[1:0];
`ifdef LSU_UNALIGNED_EN
        rt_d  = req_rt_old_i;
`endif
        if (!legal || misalign) begin
          rdata_d = 32'd0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          addr_d  = {req_addr_i[31:2], 2'b00};
          be_d    = be_req;
          wd_d    = wd_req;
          read_d  = !is_store;
          write_d = is_store;
          state_d = S_ISSUE;
        end
      end
      // The slave raises waitrequest off the command edge, so it is ignored here.
      S_ISSUE: begin
        cnt_d   = 32'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!avm_waitrequest_i) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          rdata_d = load_data;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q + 32'd1 == TIMEOUT_CYCLES) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          rdata_d = 32'd0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      op_q    <= 4'd0;
      off_q   <= 2'd0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wd_q    <= 32'd0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      cnt_q   <= 32'd0;
      rt_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
      read_q  <= read_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      rt_q    <= rt_d;
    end
  end

  assign req_ready_o      = (state_q == S_IDLE);
  assign resp_valid_o     = (state_q == S_RESP);
  assign resp_rdata_o     = rdata_q;
  assign resp_err_o       = err_q;
  assign avm_address_o    = addr_q;
  assign avm_byteenable_o = be_q;
  assign avm_read_o       = read_q;
  assign avm_write_o      = write_q;
  assign avm_writedata_o  = wd_q;
endmodule

// File: tb/tb_mips_cpu_lsu_avalon.sv
// Bench for mips_cpu_lsu_avalon: random load/store traffic against a byte-level memory model,
// with a waitrequest-inserting Avalon slave, timeout and mid-transfer reset cases.
module tb_mips_cpu_lsu_avalon;
  localparam int TMO  = 16;
  localparam logic [31:0] BASE = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0, req_rt_old = 32'd0;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] avm_address, avm_writedata, avm_readdata;
  logic [3:0]  avm_byteenable;
  logic        avm_read, avm_write;
  logic        waitreq;

  always #5 clk = ~clk;

  mips_cpu_lsu_avalon #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_rt_old_i(req_rt_old),
    .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .avm_address_o(avm_address), .avm_byteenable_o(avm_byteenable),
    .avm_read_o(avm_read), .avm_write_o(avm_write), .avm_writedata_o(avm_writedata),
    .avm_waitrequest_i(waitreq), .avm_readdata_i(avm_readdata)
  );

  // Avalon slave: RAM of 64 words with a programmable number of wait cycles per transfer.
  logic [31:0] init_val [64];
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  int          next_waits = 0;
  int          wcnt;
  bit          busy;
  int          bus_starts;
  bit          unstable;
  logic [31:0] seen_addr, seen_wd;
  logic [3:0]  seen_be;
  logic        seen_rd, seen_wr;

  assign avm_readdata = mem[avm_address[7:2]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0; waitreq <= 1'b0; wcnt <= 0; bus_starts <= 0; unstable <= 1'b0;
      for (int k = 0; k < 64; k++) mem[k] <= init_val[k];
    end else if (!busy) begin
      if (avm_read || avm_write) begin
        busy <= 1'b1; wcnt <= next_waits; waitreq <= (next_waits > 0);
        seen_addr <= avm_address; seen_be <= avm_byteenable; seen_wd <= avm_writedata;
        seen_rd <= avm_read; seen_wr <= avm_write; unstable <= 1'b0;
        bus_starts <= bus_starts + 1;
      end
    end else if (!(avm_read || avm_write)) begin
      busy <= 1'b0; waitreq <= 1'b0;
    end else begin
      if (avm_address != seen_addr || avm_byteenable != seen_be || avm_writedata != seen_wd ||
          avm_read != seen_rd || avm_write != seen_wr) unstable <= 1'b1;
      if (waitreq) begin
        wcnt <= wcnt - 1;
        if (wcnt == 1) waitreq <= 1'b0;
      end else begin
        if (avm_write)
          for (int k = 0; k < 4; k++)
            if (avm_byteenable[k]) mem[avm_address[7:2]][8*k +: 8] <= avm_writedata[8*k +: 8];
        busy <= 1'b0;
      end
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  // Reference model works on bytes of the memory word; DUT is driven and every response checked.
  task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rtold, input int waits,
                       output logic [31:0] got, output logic got_err);
    int o, idx, sz, sh, edges, starts0, e_lat;
    bit legal, e_rej, e_to, e_st;
    logic [31:0] word, e_rd, e_wd, v, ones;
    logic [3:0]  e_be;
    ones = 32'hFFFF_FFFF;
    o = int'(addr[1:0]); idx = int'(addr[7:2]); word = ref_mem[idx];
    e_st = (op >= 4'd8);
    sz = (op == 0 || op == 1 || op == 8) ? 1 : (op == 2 || op == 3 || op == 9) ? 2 : 4;
    legal = op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9, 4'd10};
`ifdef LSU_UNALIGNED_EN
    legal = legal || op == 4'd5 || op == 4'd6;
`endif
    e_rej = !legal || (op != 5 && op != 6 && (o % sz) != 0);
    e_to  = !e_rej && waits >= TMO;
    e_be = 4'd0;
    if (sz == 4) e_be = 4'hF;
    else for (int i = 0; i < sz; i++) e_be = e_be | 4'(1 << (o + i));
    e_wd = (sz == 1) ? wdata[7:0] * 32'h0101_0101 : (sz == 2) ? wdata[15:0] * 32'h0001_0001 : wdata;
    v = word >> (8 * o);
    case (op)
      4'd0: e_rd = v[7] ? (v & 32'hFF) | 32'hFFFF_FF00 : v & 32'hFF;
      4'd1: e_rd = v & 32'hFF;
      4'd2: e_rd = v[15] ? (v & 32'hFFFF) | 32'hFFFF_0000 : v & 32'hFFFF;
      4'd3: e_rd = v & 32'hFFFF;
      4'd4: e_rd = word;
      4'd5: begin sh = 8 * (3 - o); e_rd = (word << sh) | (rtold & ~(ones << sh)); end
      4'd6: begin sh = 8 * o;       e_rd = (word >> sh) | (rtold & ~(ones >> sh)); end
      default: e_rd = 32'd0;
    endcase
    if (e_rej || e_to) e_rd = 32'd0;
    e_lat = e_rej ? 1 : e_to ? TMO + 2 : 3 + waits;

    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    next_waits = waits; starts0 = bus_starts;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata; req_rt_old = rtold;
    @(posedge clk); #1;
    // Garbage with valid high while busy must be ignored.
    req_op = 4'($urandom); req_addr = $urandom; req_wdata = $urandom; req_rt_old = $urandom;
    edges = 1;
    if (!resp_valid) chk("ready_busy", req_ready, 0);
    while (!resp_valid && edges < 200) begin @(posedge clk); #1; edges++; end
    req_valid = 1'b0;
    chk("resp_latency", edges, e_lat);
    chk("resp_err", resp_err, e_rej || e_to);
    chk("resp_rdata", resp_rdata, e_rd);
    got = resp_rdata; got_err = resp_err;
    if (e_rej) chk("no_bus_cycle", bus_starts - starts0, 0);
    else begin
      chk("one_bus_cycle", bus_starts - starts0, 1);
      chk("avm_address", seen_addr, {addr[31:2], 2'b00});
      chk("avm_byteenable", seen_be, e_be);
      chk("avm_rd_wr", {seen_rd, seen_wr}, {!e_st, e_st});
      if (e_st) chk("avm_writedata", seen_wd, e_wd);
      chk("bus_stable", unstable, 0);
      chk("bus_released", {avm_read, avm_write}, 0);
    end
    @(posedge clk); #1;
    chk("resp_pulse", resp_valid, 0);
    chk("rdata_held", resp_rdata, e_rd);
    if (e_st && !e_rej && !e_to)
      for (int i = 0; i < sz; i++) begin
        word = word & ~(32'hFF << (8 * (o + i)));
        word = word | (((wdata >> (8 * i)) & 32'hFF) << (8 * (o + i)));
      end
    ref_mem[idx] = word;
  endtask

  logic [31:0] g;
  logic        ge;
  logic [3:0]  ops [13];

  initial begin
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd15};
    for (int k = 0; k < 64; k++) begin init_val[k] = $urandom; ref_mem[k] = init_val[k]; end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_avm_addr", avm_address, 0);
    chk("rst_avm_ctl", {avm_byteenable, avm_read, avm_write}, 0);
    chk("rst_avm_wd", avm_writedata, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    do_op(4'd10, BASE + 32'h10, 32'hDEAD_BEEF, 0, 2, g, ge);
    do_op(4'd4,  BASE + 32'h10, 0, 0, 0, g, ge);
    chk("ex_lw", g, 32'hDEAD_BEEF);
    do_op(4'd10, BASE + 32'h10, 32'h80FF_1234, 0, 1, g, ge);
    do_op(4'd0,  BASE + 32'h13, 0, 0, 3, g, ge);
    chk("ex_lb", g, 32'hFFFF_FF80);
    do_op(4'd1,  BASE + 32'h13, 0, 0, 0, g, ge);
    chk("ex_lbu", g, 32'h0000_0080);
    do_op(4'd10, BASE + 32'h20, 32'h1122_3344, 0, 0, g, ge);
    do_op(4'd9,  BASE + 32'h22, 32'h0000_ABCD, 0, 4, g, ge);
    do_op(4'd4,  BASE + 32'h20, 0, 0, 5, g, ge);
    chk("ex_sh_word", g, 32'hABCD_3344);
    do_op(4'd3,  BASE + 32'h22, 0, 0, 2, g, ge);
    chk("ex_lhu", g, 32'h0000_ABCD);
    do_op(4'd4,  BASE + 32'h02, 0, 0, 0, g, ge);
    chk("ex_misalign_err", ge, 1);
    do_op(4'd10, BASE + 32'h10, 32'hAABB_CCDD, 0, 0, g, ge);
    do_op(4'd5,  BASE + 32'h11, 0, 32'h1122_3344, 1, g, ge);
`ifdef LSU_UNALIGNED_EN
    chk("ex_lwl", g, 32'hCCDD_3344);
`else
    chk("ex_lwl_illegal", ge, 1);
`endif

    for (int t = 0; t < 150; t++)
      do_op(ops[$urandom_range(0, 12)], BASE + ($urandom_range(0, 63) << 2) + $urandom_range(0, 3),
            $urandom, $urandom, $urandom_range(0, 5), g, ge);

    do_op(4'd4,  BASE + 32'h30, 0, 0, 1000, g, ge);
    chk("timeout_err", ge, 1);
    do_op(4'd10, BASE + 32'h30, 32'h5A5A_5A5A, 0, TMO, g, ge);
    do_op(4'd4,  BASE + 32'h30, 0, 0, TMO - 1, g, ge);

    // Reset while the read sits in WAIT.
    @(negedge clk);
    next_waits = 5;
    req_valid = 1'b1; req_op = 4'd4; req_addr = BASE + 32'h40;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_read", avm_read, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_read", avm_read, 0);
    chk("mid_rst_ready", req_ready, 1);
    for (int c = 0; c < 4; c++) begin @(posedge clk); #1 chk("mid_rst_no_resp", resp_valid, 0); end
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 64; k++) ref_mem[k] = init_val[k];
    do_op(4'd4, BASE + 32'h40, 0, 0, 2, g, ge);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
